usb_tx_arbiter: RTL
===================

Name: usb_tx_arbiter

Overview:
Shares the single USB transmit byte interface between two requesters. The first is the register readback response stream produced during read commands. The second is asynchronous trigger event notifications, which the block queues and frames as 3-byte packets. Arbitration is packet-atomic and round-robin, with a watchdog on stalled responses. Sits between the command/register layer and the USB transmitter on clk_usb.

Parameters:
EVT_DEPTH, 8, event queue entries; power of two, at least 2.
RSP_TIMEOUT, 1024, consecutive idle cycles tolerated inside a granted response before abort; 0 disables the watchdog.

Ports:
clk_usb  in  1  system clock
reset_n  in  1  asynchronous active-low reset
rsp_valid  in  1  response byte available
rsp_data  in  8  response byte
rsp_last  in  1  final byte of response packet
rsp_ready  out  1  response byte accepted this cycle
evt_valid  in  1  event push strobe, one cycle per event
evt_code  in  6  event code
evt_payload  in  16  event payload
tx_valid  out  1  output byte valid
tx_data  out  8  output byte
tx_ready  in  1  USB transmitter accepts byte
evt_drop_cnt  out  8  saturating count of dropped events
evt_overflow  out  1  sticky flag: an event was dropped
clr_overflow  in  1  clears evt_drop_cnt and evt_overflow
rsp_timeout  out  1  one-cycle pulse when a response is aborted
busy  out  1  state != IDLE or tx_valid

Behaviour:
- Reset (async assert, sync release): state=IDLE, tx_valid=0, tx_data=0, rsp_ready=0, rsp_timeout=0, evt_drop_cnt=0, evt_overflow=0, queue empty, last_grant=EVT.
- Output register: tx_valid/tx_data are registered. "slot free" = !tx_valid || tx_ready. tx_data must stay stable while tx_valid && !tx_ready.
- Event packet format: byte0 = {2'b01, code}, byte1 = payload[7:0], byte2 = payload[15:8].
- Mode encoding: 2'b01 = event notify, distinct from read 2'b10 and write 2'b11.
- Event queue:
  - evt_valid pushes {code, payload} if the queue is not full.
  - If full and no pop occurs that cycle, the event is dropped: evt_drop_cnt increments, saturating at 255, and evt_overflow is set.
  - Push on a full queue in the same cycle as a pop is accepted.
- Overflow clear: clr_overflow clears evt_drop_cnt and evt_overflow. If clr and a drop occur in the same cycle, the result is cnt=1, overflow=1.
- State machine: IDLE, RSP, EVT_HDR, EVT_LO, EVT_HI.
- IDLE arbitration:
  - If only rsp_valid: go to RSP.
  - If only the queue is non-empty: go to EVT_HDR.
  - If both: grant the requester opposite to last_grant, so the first tie after reset goes to the response.
  - The grant decision costs one cycle; no byte is transferred in IDLE.
- RSP state:
  - rsp_ready = (state==RSP) && slot free; combinational, asserted only in RSP.
  - Byte accepted when rsp_valid && rsp_ready: load tx_data, set tx_valid next cycle (latency 1).
  - Accepting a byte with rsp_last: go to IDLE, last_grant=RSP.
- Event states: each of EVT_HDR, EVT_LO and EVT_HI loads its byte when the slot is free, then advances. The queue entry pops when the EVT_HI byte loads; then go to IDLE, last_grant=EVT.
- Watchdog:
  - In RSP, a counter increments each cycle with no accepted byte and clears on each accepted byte.
  - When it reaches RSP_TIMEOUT (non-zero), pulse rsp_timeout for one cycle, go to IDLE, set last_grant=RSP.
  - Bytes already loaded still drain.
- Packets are never interleaved; the event queue keeps filling while a response is granted.
- Reset mid-packet: the packet is lost, the output clears immediately and the queue empties; no recovery framing is sent.

Decomposition:
- Shared package usb_proto_pkg:
  - MODE_EVENT=2'b01, MODE_READ=2'b10, MODE_WRITE=2'b11, CMD_MASK=8'h3F.
  - Arbiter state encoding constants.
  - Event entry width constant (22).
- One sub-module: evt_fifo (synchronous FIFO, width 22, depth EVT_DEPTH, full/empty flags, push/pop same-cycle safe).

Test Plan:
1. One event, code 6'h05, payload 16'h1234, tx_ready=1 -> tx bytes 0x45, 0x34, 0x12 on consecutive accepts; queue empty; busy drops after the last accept.
2. Response AA BB CC DD (last on DD) and event code 6'h01 payload 16'h00FF arrive in the same cycle -> AA BB CC DD, then 0x41, 0xFF, 0x00. A second simultaneous tie then grants the event first.
3. tx_ready held low 5 cycles while 0x34 is presented -> tx_data stays 0x34 with tx_valid=1; the sequence completes with no loss or duplication.
4. EVT_DEPTH=4, tx_ready=0, 6 events pushed -> evt_drop_cnt=2, evt_overflow=1. clr_overflow alone -> 0/0. clr together with a drop -> 1/1.
5. RSP_TIMEOUT=16: response stalls after 2 bytes -> rsp_timeout pulses exactly on the 16th idle cycle, state returns to IDLE, and a pending event is sent next.
6. reset_n asserted during EVT_LO -> tx_valid=0 asynchronously; after release the queue is empty, state is IDLE, and no stray bytes appear.

Source files
------------

// File: rtl/usb_proto_pkg.sv
// Shared USB protocol constants, arbiter state encoding and event entry layout.
package usb_proto_pkg;

    // Mode field carried in the top two bits of a header byte.
    localparam logic [1:0] MODE_EVENT = 2'b01;
    localparam logic [1:0] MODE_READ  = 2'b10;
    localparam logic [1:0] MODE_WRITE = 2'b11;
    localparam logic [7:0] CMD_MASK   = 8'h3F;

    // Queued event entry: {code[5:0], payload[15:0]}.
    localparam int unsigned EVT_W = 22;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StRsp    = 3'd1,
        StEvtHdr = 3'd2,
        StEvtLo  = 3'd3,
        StEvtHi  = 3'd4
    } arb_state_e;

    typedef enum logic {
        GrantEvt = 1'b0,
        GrantRsp = 1'b1
    } grant_e;

    typedef struct packed {
        logic [5:0]  code;
        logic [15:0] payload;
    } evt_entry_t;

    function automatic logic [7:0] evt_hdr_byte(input logic [5:0] code);
        return {MODE_EVENT, code};
    endfunction

endpackage

// File: rtl/usb_tx_arbiter_if.sv
// Response, event and transmit byte streams shared by the arbiter and its neighbours.
interface usb_tx_arbiter_if;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_last;
    logic        rsp_ready;
    logic        evt_valid;
    logic [5:0]  evt_code;
    logic [15:0] evt_payload;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    // Arbiter side.
    modport slave (
        input  rsp_valid, rsp_data, rsp_last, evt_valid, evt_code, evt_payload, tx_ready,
        output rsp_ready, tx_valid, tx_data
    );

    // Producer / transmitter side.
    modport master (
        output rsp_valid, rsp_data, rsp_last, evt_valid, evt_code, evt_payload, tx_ready,
        input  rsp_ready, tx_valid, tx_data
    );
endinterface

// File: rtl/evt_fifo.sv
// Synchronous event FIFO; a push while full is accepted only if a pop happens the same cycle.
module evt_fifo
    import usb_proto_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = EVT_W
) (
    input  logic             clk_usb,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    cnt_q, cnt_d;
    logic             wr_en, rd_en;

    assign full_o  = (cnt_q == (PtrW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state; pointers wrap naturally (power-of-two depth).
    always_comb begin
        wr_en    = push_i && (!full_o || pop_i);
        rd_en    = pop_i && !empty_o;
        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q + (PtrW+1)'(wr_en) - (PtrW+1)'(rd_en);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage; contents are don't-care while empty so no reset is needed.
    always_ff @(posedge clk_usb) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/usb_tx_arbiter.sv
// Packet-atomic round-robin arbiter between the register response stream and queued
// 3-byte event notifications, driving one registered USB transmit byte stream.
module usb_tx_arbiter
    import usb_proto_pkg::*;
#(
    parameter int unsigned EVT_DEPTH   = 8,
    parameter int unsigned RSP_TIMEOUT = 1024
) (
    input  logic              clk_usb,
    input  logic              reset_n,
    usb_tx_arbiter_if.slave   bus,
    input  logic              clr_overflow,
    output logic [7:0]        evt_drop_cnt,
    output logic              evt_overflow,
    output logic              rsp_timeout,
    output logic              busy
);
    localparam int unsigned WdW    = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;
    localparam bit          WdEn   = (RSP_TIMEOUT != 0);
    localparam logic [WdW-1:0] WdLast = WdW'(RSP_TIMEOUT - 1);

    arb_state_e       state_q, state_d;
    grant_e           grant_q, grant_d;
    logic [WdW-1:0]   wd_cnt_q, wd_cnt_d;
    logic             timeout_q, timeout_d;
    logic             tx_valid_q, tx_valid_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    logic             ovf_q, ovf_d;

    logic             slot_free, load, pop, drop, rsp_ready;
    logic [7:0]       load_byte;
    logic             fifo_full, fifo_empty;
    logic [EVT_W-1:0] head_raw;
    evt_entry_t       head;

    assign head = evt_entry_t'(head_raw);

    evt_fifo #(
        .DEPTH (EVT_DEPTH),
        .WIDTH (EVT_W)
    ) u_evt_fifo (
        .clk_usb (clk_usb),
        .reset_n (reset_n),
        .push_i  (bus.evt_valid),
        .wdata_i ({bus.evt_code, bus.evt_payload}),
        .pop_i   (pop),
        .rdata_o (head_raw),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Arbitration FSM, watchdog and output-byte selection.
    always_comb begin
        slot_free = !tx_valid_q || bus.tx_ready;
        state_d   = state_q;
        grant_d   = grant_q;
        wd_cnt_d  = wd_cnt_q;
        timeout_d = 1'b0;
        load      = 1'b0;
        load_byte = 8'h00;
        pop       = 1'b0;
        rsp_ready = 1'b0;
        unique case (state_q)
            StIdle: begin
                wd_cnt_d = '0;
                if (bus.rsp_valid && !fifo_empty) begin
                    state_d = (grant_q == GrantEvt) ? StRsp : StEvtHdr;
                end else if (bus.rsp_valid) begin
                    state_d = StRsp;
                end else if (!fifo_empty) begin
                    state_d = StEvtHdr;
                end
            end
            StRsp: begin
                rsp_ready = slot_free;
                if (bus.rsp_valid && slot_free) begin
                    load      = 1'b1;
                    load_byte = bus.rsp_data;
                    wd_cnt_d  = '0;
                    if (bus.rsp_last) begin
                        state_d = StIdle;
                        grant_d = GrantRsp;
                    end
                end else if (WdEn && (wd_cnt_q == WdLast)) begin
                    // Stalled producer: abandon the packet; loaded bytes still drain.
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                    grant_d   = GrantRsp;
                    wd_cnt_d  = '0;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
            end
            StEvtHdr: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_byte = evt_hdr_byte(head.code);
                    state_d   = StEvtLo;
                end
            end
            StEvtLo: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_byte = head.payload[7:0];
                    state_d   = StEvtHi;
                end
            end
            StEvtHi: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_byte = head.payload[15:8];
                    pop       = 1'b1;
                    state_d   = StIdle;
                    grant_d   = GrantEvt;
                end
            end
            default: state_d = StIdle;
        endcase

        tx_valid_d = load ? 1'b1 : (bus.tx_ready ? 1'b0 : tx_valid_q);
        tx_data_d  = load ? load_byte : tx_data_q;
    end

    // Drop accounting; a same-cycle clear and drop leaves one counted drop.
    always_comb begin
        drop       = bus.evt_valid && fifo_full && !pop;
        drop_cnt_d = drop_cnt_q;
        ovf_d      = ovf_q;
        if (clr_overflow) begin
            drop_cnt_d = '0;
            ovf_d      = 1'b0;
        end
        if (drop) begin
            ovf_d      = 1'b1;
            drop_cnt_d = (drop_cnt_d == 8'hFF) ? 8'hFF : drop_cnt_d + 8'd1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            grant_q    <= GrantEvt;
            wd_cnt_q   <= '0;
            timeout_q  <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            drop_cnt_q <= 8'h00;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            wd_cnt_q   <= wd_cnt_d;
            timeout_q  <= timeout_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            drop_cnt_q <= drop_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.rsp_ready = rsp_ready;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.tx_data   = tx_data_q;
    assign evt_drop_cnt  = drop_cnt_q;
    assign evt_overflow  = ovf_q;
    assign rsp_timeout   = timeout_q;
    assign busy          = (state_q != StIdle) || tx_valid_q;

endmodule
